semi_auto_nav_ctrl: RTL

Parametrised semi-automatic navigation controller for the maze car, the successor to the fixed 100 Hz semi-auto FSM.
- Runs entirely on the system clock, with an internal tick prescaler, debounced obstacle detectors and edge-detected driver commands.
- Durations are configurable, junction auto-decision is selectable, and the turn-back manoeuvre has a selectable style.
- Sits between the mode selector / button conditioner and the motor-drive mux; outputs are one-hot motion requests.

---
 rtl/semi_auto_nav_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/semi_auto_nav_ctrl.sv
// semi_auto_nav_ctrl
//   Semi-automatic navigation controller for the maze car. Runs on the system
//   clock with an internal tick prescaler. Obstacle detectors are debounced on
//   ticks. Driver commands are rising-edge detected and held as pending bits
//   while waiting. One-hot motion requests go to the motor-drive mux.
//
// Ports
//   clk                    system clock
//   reset                  synchronous, active-high
//   semi_auto_mode_on      enable; 0 pauses the controller and zeroes outputs
//   front/back/left/right_detector   raw obstacle inputs, 1 = obstacle
//   go_straight/turn_right/turn_left/turn_back_command
//                          level inputs; a rising edge is a command
//   move_forward, turn_left, turn_right, move_backward
//                          registered motion requests, at most one high
//   state_o                current state (000 WAIT, 001 TURN_R, 010 TURN_L,
//                          011 STRAIGHT, 100 TURN_BACK)
//   tick_o                 one-clock prescaler pulse
module semi_auto_nav_ctrl #(
  parameter int CLK_HZ        = 100000000,
  parameter int TICK_HZ       = 100,
  parameter int CNT_W         = 16,
  parameter int SETTLE_TICKS  = 90,
  parameter int TURN_TICKS    = 90,
  parameter int BACK_TICKS    = 180,
  parameter int DEB_TICKS     = 3,
  parameter int AUTO_JUNCTION = 1,
  parameter int BACK_MODE     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       semi_auto_mode_on,
  input  logic       front_detector,
  input  logic       back_detector,
  input  logic       left_detector,
  input  logic       right_detector,
  input  logic       go_straight_command,
  input  logic       turn_right_command,
  input  logic       turn_left_command,
  input  logic       turn_back_command,
  output logic       move_forward,
  output logic       turn_left,
  output logic       turn_right,
  output logic       move_backward,
  output logic [2:0] state_o,
  output logic       tick_o
);

  localparam int PRESC = CLK_HZ / TICK_HZ;
  localparam int PW    = $clog2(PRESC);
  localparam int DW    = $clog2(DEB_TICKS + 1);

  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC - 1);
  localparam logic [DW-1:0]    DEB_LAST   = DW'(DEB_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] SETTLE_C   = CNT_W'(SETTLE_TICKS);
  localparam logic [CNT_W-1:0] TURN_C     = CNT_W'(TURN_TICKS);
  localparam logic [CNT_W-1:0] BACK_C     = CNT_W'(BACK_TICKS);

  typedef enum logic [2:0] {
    S_WAIT      = 3'b000,
    S_TURN_R    = 3'b001,
    S_TURN_L    = 3'b010,
    S_STRAIGHT  = 3'b011,
    S_TURN_BACK = 3'b100
  } state_t;

  state_t            state, state_next;
  logic              state_bad;
  logic [PW-1:0]     presc;
  logic              tick;
  logic [3:0]        det_raw, det_deb;
  logic [3:0][DW-1:0] deb_cnt;
  logic              deb_f, deb_l, deb_r;
  logic              back_deb_unused;
  logic [3:0]        cmd_lvl, cmd_prev, cmd_edge, cmd_pend;
  logic [CNT_W-1:0]  counter, cnt_inc, counter_next;
  logic [3:0]        motion, motion_next;

  // Channel order {back, front, left, right}; command order is the priority
  // order {straight, right, left, back}, highest first.
  assign det_raw  = {back_detector, front_detector, left_detector, right_detector};
  assign cmd_lvl  = {go_straight_command, turn_right_command, turn_left_command, turn_back_command};
  assign cmd_edge = cmd_lvl & ~cmd_prev;
  assign deb_f    = det_deb[2];
  assign deb_l    = det_deb[1];
  assign deb_r    = det_deb[0];
  // The back channel is debounced like the others but plays no part in any
  // decision.
  assign back_deb_unused = det_deb[3];

  assign tick = semi_auto_mode_on && (presc == PRESC_LAST);

  // Thresholds are compared against the count including the current tick,
  // so a transition and its counter clear land on the same tick.
  assign cnt_inc = (counter == CNT_MAX) ? counter : counter + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (semi_auto_mode_on) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      det_deb <= '0;
      deb_cnt <= '0;
    end else if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (det_raw[i] != det_deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            det_deb[i] <= det_raw[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // The previous-level register tracks the inputs even while paused, so a
  // level raised during a pause never shows up as an edge afterwards.
  // Pending bits only live in WAIT and are dropped when WAIT is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_prev <= '0;
      cmd_pend <= '0;
    end else begin
      cmd_prev <= cmd_lvl;
      if (semi_auto_mode_on) begin
        if (state != S_WAIT || state_next != S_WAIT) begin
          cmd_pend <= '0;
        end else begin
          cmd_pend <= cmd_pend | cmd_edge;
        end
      end
    end
  end

  always_comb begin
    state_next  = state;
    state_bad   = 1'b0;
    motion_next = 4'b0000;
    case (state)
      S_WAIT: begin
        if (tick) begin
          if (cmd_pend[3])      state_next = S_STRAIGHT;
          else if (cmd_pend[2]) state_next = S_TURN_R;
          else if (cmd_pend[1]) state_next = S_TURN_L;
          else if (cmd_pend[0]) state_next = S_TURN_BACK;
        end
      end
      S_STRAIGHT: begin
        motion_next = 4'b1000;
        if (tick && cnt_inc >= SETTLE_C) begin
          if (!deb_f) begin
            if (!(deb_l && deb_r)) state_next = S_WAIT;
          end else if (AUTO_JUNCTION == 0) begin
            state_next = S_WAIT;
          end else begin
            case ({deb_l, deb_r})
              2'b10:   state_next = S_TURN_R;
              2'b01:   state_next = S_TURN_L;
              2'b11:   state_next = S_TURN_BACK;
              default: state_next = S_WAIT;
            endcase
          end
        end
      end
      S_TURN_R: begin
        motion_next = 4'b0010;
        if (tick && cnt_inc >= TURN_C && !deb_f) state_next = S_STRAIGHT;
      end
      S_TURN_L: begin
        motion_next = 4'b0100;
        if (tick && cnt_inc >= TURN_C && !deb_f) state_next = S_STRAIGHT;
      end
      S_TURN_BACK: begin
        motion_next = (BACK_MODE != 0) ? 4'b0001 : 4'b0010;
        if (tick && cnt_inc >= BACK_C) state_next = S_STRAIGHT;
      end
      default: begin
        state_next = S_WAIT;
        state_bad  = 1'b1;
      end
    endcase

    if (state_next != state) begin
      counter_next = '0;
    end else if (tick) begin
      counter_next = cnt_inc;
    end else begin
      counter_next = counter;
    end
  end

  // An illegal code is recovered even while paused.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_STRAIGHT;
      counter <= '0;
    end else if (semi_auto_mode_on || state_bad) begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      motion <= 4'b0000;
    end else if (semi_auto_mode_on) begin
      motion <= motion_next;
    end else begin
      motion <= 4'b0000;
    end
  end

  assign move_forward  = motion[3];
  assign turn_left     = motion[2];
  assign turn_right    = motion[1];
  assign move_backward = motion[0];
  assign state_o       = state;
  assign tick_o        = tick;

endmodule
